// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CYCLES_W = 32;

  // Number of valid output positions along one side.
  function automatic int outs_f(input int size, input int ker);
    return size - ker + 1;
  endfunction

  // Index width for n distinct values, never narrower than one bit.
  function automatic int width_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_win_counter.sv
// Nested out_r/out_c/kr/kc window counter with tap flags and image address sums.
module conv_win_counter
  import conv_pkg::*;
#(
  parameter int SIZE    = 256,
  parameter int SIZEKer = 3
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic                                enable,
  output logic [width_f(SIZE)-1:0]            img_row,
  output logic [width_f(SIZE)-1:0]            img_col,
  output logic [width_f(SIZEKer*SIZEKer)-1:0] ker_idx,
  output logic                                first,
  output logic                                last,
  output logic                                wrap
);

  localparam int OUTS = outs_f(SIZE, SIZEKer);
  localparam int RW   = width_f(SIZE);
  localparam int KW   = width_f(SIZEKer * SIZEKer);
  localparam int OW   = width_f(OUTS);
  localparam int CW   = width_f(SIZEKer);
  localparam logic [OW-1:0] OMAX = OW'(OUTS - 1);
  localparam logic [CW-1:0] KMAX = CW'(SIZEKer - 1);

  logic [OW-1:0] out_r, out_c;
  logic [CW-1:0] kr, kc;

  // Advance kc innermost on each accepted tap; hold once the final tap has gone.
  always_ff @(posedge clock) begin
    if (clear) begin
      out_r <= '0;
      out_c <= '0;
      kr    <= '0;
      kc    <= '0;
    end else if (enable && !wrap) begin
      if (kc == KMAX) begin
        kc <= '0;
        if (kr == KMAX) begin
          kr <= '0;
          if (out_c == OMAX) begin
            out_c <= '0;
            out_r <= out_r + 1'b1;
          end else begin
            out_c <= out_c + 1'b1;
          end
        end else begin
          kr <= kr + 1'b1;
        end
      end else begin
        kc <= kc + 1'b1;
      end
    end
  end

  // Flags and addresses are pure functions of the held counter state.
  always_comb begin
    first   = (kr == '0) && (kc == '0);
    last    = (kr == KMAX) && (kc == KMAX);
    wrap    = last && (out_r == OMAX) && (out_c == OMAX);
    img_row = RW'(out_r) + RW'(kr);
    img_col = RW'(out_c) + RW'(kc);
    ker_idx = KW'(kr) * KW'(SIZEKer) + KW'(kc);
  end

endmodule

// File: rtl/conv_window_sched.sv
// Convolution tap sequencer: issues window taps to a shared MAC with an
// in-flight limit, and turns returning MAC results into raster-order writes.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int SIZE         = 256,
  parameter int SIZEKer      = 3,
  parameter int WIDTH_BIT    = 16,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   tap_valid,
  input  logic                                   tap_ready,
  output logic [width_f(SIZE)-1:0]               img_row,
  output logic [width_f(SIZE)-1:0]               img_col,
  output logic [width_f(SIZEKer*SIZEKer)-1:0]    ker_idx,
  output logic                                   tap_first,
  output logic                                   tap_last,
  input  logic                                   res_valid,
  input  logic signed [WIDTH_BIT-1:0]            res_data,
  output logic                                   out_we,
  output logic [width_f(outs_f(SIZE,SIZEKer))-1:0] out_row,
  output logic [width_f(outs_f(SIZE,SIZEKer))-1:0] out_col,
  output logic signed [WIDTH_BIT-1:0]            out_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [CYCLES_W-1:0]                    cycles
);

  localparam int OUTS = outs_f(SIZE, SIZEKer);
  localparam int OW   = width_f(OUTS);
  localparam int IW   = width_f(MAX_INFLIGHT + 1);
  localparam int NW   = width_f(OUTS * OUTS + 1);
  localparam logic [OW-1:0] OMAX = OW'(OUTS - 1);
  localparam logic [IW-1:0] IMAX = IW'(MAX_INFLIGHT);
  localparam logic [NW-1:0] NWR  = NW'(OUTS * OUTS);

  state_t state_q, state_d;
  logic go, hs, res_ok, win_wrap, err_sticky;
  logic [IW-1:0] inflight_q;
  logic [OW-1:0] wr_r, wr_c;
  logic [NW-1:0] wr_cnt;
  logic [CYCLES_W-1:0] cyc_q;
  logic vld_p1;
  logic [OW-1:0] row_p1, col_p1;
  logic signed [WIDTH_BIT-1:0] data_p1;

  conv_win_counter #(
    .SIZE   (SIZE),
    .SIZEKer(SIZEKer)
  ) u_win (
    .clock  (clock),
    .clear  (reset || go),
    .enable (hs),
    .img_row(img_row),
    .img_col(img_col),
    .ker_idx(ker_idx),
    .first  (tap_first),
    .last   (tap_last),
    .wrap   (win_wrap)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and status outputs; a new output is held back while the MAC is full.
  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    tap_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          go      = 1'b1;
        end
      end
      RUN: begin
        busy      = 1'b1;
        tap_valid = !(tap_first && (inflight_q == IMAX));
        if (tap_valid && tap_ready && win_wrap) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_cnt == NWR) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = RUN;
          go      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs     = tap_valid && tap_ready;
  assign res_ok = res_valid && busy && (inflight_q != '0);

  // Outputs issued to the MAC but not yet returned.
  always_ff @(posedge clock) begin
    if (reset || go) begin
      inflight_q <= '0;
    end else begin
      case ({hs && tap_last, res_ok})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Raster-order write position, independent of the issue counters.
  always_ff @(posedge clock) begin
    if (reset || go) begin
      wr_r   <= '0;
      wr_c   <= '0;
      wr_cnt <= '0;
    end else if (res_ok) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_c == OMAX) begin
        wr_c <= '0;
        if (wr_r != OMAX) wr_r <= wr_r + 1'b1;
      end else begin
        wr_c <= wr_c + 1'b1;
      end
    end
  end

  // Stage p1: write strobe and address one cycle after an accepted result.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
      col_p1 <= '0;
    end else begin
      vld_p1 <= res_ok;
      if (res_ok) begin
        row_p1 <= wr_r;
        col_p1 <= wr_c;
      end
    end
  end

  // Stage p1 data: captured with the strobe, no reset on the data path.
  always_ff @(posedge clock) begin
    if (res_ok) data_p1 <= res_data;
  end

  assign out_we   = vld_p1;
  assign out_row  = row_p1;
  assign out_col  = col_p1;
  assign out_data = data_p1;

  // Saturating count of RUN+DRAIN cycles for the current pass.
  always_ff @(posedge clock) begin
    if (reset || go)                  cyc_q <= '0;
    else if (busy && (cyc_q != '1))   cyc_q <= cyc_q + 1'b1;
  end

  assign cycles = cyc_q;

  // Sticky flag for a result arriving with nothing outstanding.
  always_ff @(posedge clock) begin
    if (reset)                                           err_sticky <= 1'b0;
    else if (res_valid && busy && (inflight_q == '0))    err_sticky <= 1'b1;
  end

  assert property (@(posedge clock) disable iff (reset) !err_sticky);

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched on a 5x5 ramp image with a MAC model.
module tb_conv_window_sched;
  import conv_pkg::*;

  localparam int SZ = 5;
  localparam int NI = 4;

  function automatic int kof(input int g);
    return (g == 2) ? 1 : (g == 3) ? 5 : 3;
  endfunction
  function automatic int mif(input int g);
    return (g == 1) ? 2 : 4;
  endfunction
  function automatic int pix(input int r, input int c);
    return r * SZ + c + 1;
  endfunction
  function automatic int coef(input int k);
    return k - 4;
  endfunction
  function automatic int golden(input int orr, input int oc, input int k);
    int s;
    s = 0;
    for (int kr = 0; kr < k; kr++)
      for (int kc = 0; kc < k; kc++)
        s += pix(orr + kr, oc + kc) * coef(kr * k + kc);
    return s;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NI-1:0] start_a, tap_ready_a, res_valid_a;
  logic signed [15:0] res_data_a [NI];
  wire  [NI-1:0] tap_valid_a, tap_first_a, tap_last_a, out_we_a, busy_a, done_a;
  wire  [7:0] row_a [NI];
  wire  [7:0] col_a [NI];
  wire  [7:0] kidx_a [NI];
  wire  [7:0] orow_a [NI];
  wire  [7:0] ocol_a [NI];
  wire  signed [15:0] out_data_a [NI];
  wire  [31:0] cycles_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int K  = kof(g);
    localparam int RW = width_f(SZ);
    localparam int KW = width_f(K * K);
    localparam int OW = width_f(SZ - K + 1);
    logic [RW-1:0] r, c;
    logic [KW-1:0] k;
    logic [OW-1:0] orr, occ;
    conv_window_sched #(
      .SIZE(SZ), .SIZEKer(K), .WIDTH_BIT(16), .MAX_INFLIGHT(mif(g))
    ) u_dut (
      .clock(clk), .reset(reset), .start(start_a[g]),
      .tap_valid(tap_valid_a[g]), .tap_ready(tap_ready_a[g]),
      .img_row(r), .img_col(c), .ker_idx(k),
      .tap_first(tap_first_a[g]), .tap_last(tap_last_a[g]),
      .res_valid(res_valid_a[g]), .res_data(res_data_a[g]),
      .out_we(out_we_a[g]), .out_row(orr), .out_col(occ), .out_data(out_data_a[g]),
      .busy(busy_a[g]), .done(done_a[g]), .cycles(cycles_a[g])
    );
    assign row_a[g]  = 8'(r);
    assign col_a[g]  = 8'(c);
    assign kidx_a[g] = 8'(k);
    assign orow_a[g] = 8'(orr);
    assign ocol_a[g] = 8'(occ);
  end

  typedef struct { int due; int val; } mac_t;
  typedef struct { int r; int c; int val; } exp_t;
  mac_t mac_q[$];
  exp_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int sel, kcur, lat, rdy_mode, cyc;
  int ntaps, nwr, nbusy, acc, inflight_m, max_inflight;
  int first_cnt, third_first_cyc, first_res_cyc;
  int addr_bad, flag_bad, hold_bad, nhold;
  int ft_r, ft_c, ft_k, ft_first;
  int prev_r, prev_c, prev_k;
  bit prev_stall;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: score writes, return MAC results, drive ready, model accepted taps.
  task automatic step();
    int r, c, k, o, t, outs;
    bit tv, fst, lst;
    exp_t e;
    mac_t m;
    @(negedge clk);
    cyc++;
    if (busy_a[sel]) nbusy++;
    if (out_we_a[sel]) begin
      nwr++;
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_row", int'(orow_a[sel]), e.r);
        check("wr_col", int'(ocol_a[sel]), e.c);
        check("wr_data", int'(out_data_a[sel]), e.val);
      end
    end
    res_valid_a = '0;
    if (mac_q.size() != 0 && mac_q[0].due <= cyc) begin
      m = mac_q.pop_front();
      res_valid_a[sel] = 1'b1;
      res_data_a[sel]  = 16'(m.val);
      inflight_m--;
      if (first_res_cyc < 0) first_res_cyc = cyc;
    end
    tap_ready_a = '0;
    tap_ready_a[sel] = (rdy_mode == 0) || (cyc % 2 == 0);
    r = int'(row_a[sel]); c = int'(col_a[sel]); k = int'(kidx_a[sel]);
    tv = tap_valid_a[sel]; fst = tap_first_a[sel]; lst = tap_last_a[sel];
    if (prev_stall) begin
      nhold++;
      if (!tv || r != prev_r || c != prev_c || k != prev_k) hold_bad++;
    end
    prev_stall = tv && !tap_ready_a[sel];
    prev_r = r; prev_c = c; prev_k = k;
    if (tv && tap_ready_a[sel]) begin
      outs = SZ - kcur + 1;
      o = ntaps / (kcur * kcur);
      t = ntaps % (kcur * kcur);
      if (r != o / outs + t / kcur || c != o % outs + t % kcur || k != t) addr_bad++;
      if (fst != (t == 0) || lst != (t == kcur * kcur - 1)) flag_bad++;
      if (ntaps == 0) begin
        ft_r = r; ft_c = c; ft_k = k; ft_first = int'(fst);
      end
      if (fst) begin
        acc = 0;
        first_cnt++;
        if (first_cnt == 3) third_first_cyc = cyc;
      end
      acc += pix(r, c) * coef(k);
      if (lst) begin
        mac_q.push_back('{cyc + lat, acc});
        exp_q.push_back('{o / outs, o % outs, golden(o / outs, o % outs, kcur)});
        inflight_m++;
        if (inflight_m > max_inflight) max_inflight = inflight_m;
      end
      ntaps++;
    end
  endtask

  task automatic begin_pass(input int s, input int l, input int rm);
    sel = s; kcur = kof(s); lat = l; rdy_mode = rm;
    ntaps = 0; nwr = 0; nbusy = 0; acc = 0; inflight_m = 0; max_inflight = 0;
    first_cnt = 0; third_first_cyc = -1; first_res_cyc = -1;
    addr_bad = 0; flag_bad = 0; hold_bad = 0; nhold = 0; prev_stall = 1'b0;
    exp_q.delete();
    start_a[sel] = 1'b1;
    step();
    start_a[sel] = 1'b0;
  endtask

  task automatic run_pass(input string tag);
    int n, outs;
    n = 0;
    outs = SZ - kcur + 1;
    while (!done_a[sel] && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_done"}, int'(done_a[sel]), 1);
    check({tag, "_taps"}, ntaps, outs * outs * kcur * kcur);
    check({tag, "_writes"}, nwr, outs * outs);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_addr_bad"}, addr_bad, 0);
    check({tag, "_flag_bad"}, flag_bad, 0);
    check({tag, "_cycles"}, int'(cycles_a[sel]), nbusy);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tap_valid"}, int'(tap_valid_a[sel]), 0);
    check({tag, "_busy"}, int'(busy_a[sel]), 0);
    check({tag, "_done"}, int'(done_a[sel]), 0);
    check({tag, "_out_we"}, int'(out_we_a[sel]), 0);
    check({tag, "_cycles"}, int'(cycles_a[sel]), 0);
    check({tag, "_img_row"}, int'(row_a[sel]), 0);
    check({tag, "_img_col"}, int'(col_a[sel]), 0);
    check({tag, "_ker_idx"}, int'(kidx_a[sel]), 0);
    check({tag, "_out_row"}, int'(orow_a[sel]), 0);
  endtask

  initial begin
    int n, saved;
    reset = 1'b1; start_a = '0; tap_ready_a = '0; res_valid_a = '0;
    for (int i = 0; i < NI; i++) res_data_a[i] = '0;
    sel = 0; kcur = 3; lat = 2; rdy_mode = 0; cyc = 0; prev_stall = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    // Basic pass, ready held high, 2-cycle MAC.
    begin_pass(0, 2, 0);
    run_pass("t1");
    check("t1_first_row", ft_r, 0);
    check("t1_first_col", ft_c, 0);
    check("t1_first_k", ft_k, 0);
    check("t1_first_flag", ft_first, 1);

    // Ready toggling every cycle.
    begin_pass(0, 2, 1);
    run_pass("t2");
    check("t2_hold_bad", hold_bad, 0);
    check("t2_hold_seen", int'(nhold > 0), 1);

    // Long MAC latency against an in-flight limit of two.
    begin_pass(1, 40, 0);
    run_pass("t3");
    check("t3_max_inflight", max_inflight, 2);
    check("t3_third_first_after_res", int'(third_first_cyc > first_res_cyc), 1);

    // Reset mid-pass with results still in the MAC.
    begin_pass(0, 10, 0);
    n = 0;
    while (ntaps < 30 && n < 500) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    check_idle("t4_rst");
    exp_q.delete();
    reset = 1'b0;
    saved = nwr;
    repeat (15) step();
    check("t4_stale_writes", nwr, saved);
    check("t4_stale_drained", mac_q.size(), 0);
    begin_pass(0, 2, 0);
    run_pass("t4b");

    // Degenerate kernels.
    begin_pass(2, 2, 0);
    run_pass("t5k1");
    begin_pass(3, 2, 0);
    run_pass("t5k5");

    // Start while busy is ignored; start in DONE restarts.
    begin_pass(0, 2, 0);
    repeat (10) step();
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    check("t6_busy_kept", int'(busy_a[0]), 1);
    run_pass("t6a");
    begin_pass(0, 2, 0);
    check("t6_done_drop", int'(done_a[0]), 0);
    check("t6_busy_again", int'(busy_a[0]), 1);
    check("t6_cycles_clr", int'(cycles_a[0]), 0);
    run_pass("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
